// File: rtl/phase_pkg.sv
// Shared types and helpers for the 8-phase divider monitor.
// Legal codes are the left-rotations of PH_BASE.
package phase_pkg;

    localparam logic [7:0] PH_BASE = 8'h0F;

    typedef enum logic {ACQ, LOCKED} state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } code_t;

    function automatic logic [7:0] rotl8(input logic [7:0] v,
                                         input logic [2:0] n);
        return (v << n) | (v >> (4'd8 - {1'b0, n}));
    endfunction

    function automatic code_t code_to_idx(input logic [7:0] v);
        code_t r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (v == rotl8(PH_BASE, 3'(k))) begin
                r.valid = 1'b1;
                r.idx   = 3'(k);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/phase_decode.sv
// Combinational classifier for the current/previous phase samples.
// match is pure rotation; legality of p is qualified by the caller.
module phase_decode
    import phase_pkg::*;
(
    input  logic [7:0] s,
    input  logic [7:0] p,
    output logic       legal_s,
    output logic       legal_p,
    output logic       match,
    output logic [2:0] idx
);

    code_t cs;
    code_t cp;

    always_comb begin
        cs      = code_to_idx(s);
        cp      = code_to_idx(p);
        legal_s = cs.valid;
        legal_p = cp.valid;
        idx     = cs.idx;
        match   = (s == {p[6:0], p[7]});
    end

endmodule

// File: rtl/phase_monitor.sv
// Lock/error monitor for the divide-by-8 eight-phase outputs.
// Samples ph_in, checks each sample against its predecessor.
module phase_monitor #(
    parameter int LOCK_CYC  = 16,
    parameter int ERR_LIMIT = 2,
    parameter int ERR_W     = 8
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic [7:0]       ph_in,
    input  logic             err_clr,
    output logic             locked,
    output logic [2:0]       phase_idx,
    output logic             tick,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);
    import phase_pkg::*;

    localparam int RUN_W  = $clog2(LOCK_CYC);
    localparam int MISS_W = (ERR_LIMIT > 1) ? $clog2(ERR_LIMIT) : 1;
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CYC - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(ERR_LIMIT - 1);

    logic [7:0]        s, p;
    logic              sv, pv;
    state_t            state, state_n;
    logic [RUN_W-1:0]  run_cnt, run_n;
    logic [MISS_W-1:0] miss_cnt, miss_n;
    logic              tick_n, err_n;
    logic [ERR_W-1:0]  cnt_n;
    logic              legal_s, legal_p, match, good;
    logic [2:0]        idx;

    phase_decode u_dec (
        .s       (s),
        .p       (p),
        .legal_s (legal_s),
        .legal_p (legal_p),
        .match   (match),
        .idx     (idx)
    );

    assign good   = legal_p && match;
    assign locked = (state == LOCKED);

    always_comb begin
        state_n = state;
        run_n   = run_cnt;
        miss_n  = miss_cnt;
        err_n   = 1'b0;
        if (pv) begin
            unique case (state)
                ACQ: begin
                    if (!good) begin
                        run_n = '0;
                    end else if (run_cnt == RUN_LAST) begin
                        state_n = LOCKED;
                        run_n   = '0;
                        miss_n  = '0;
                    end else begin
                        run_n = run_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        miss_n = '0;
                    end else begin
                        err_n = 1'b1;
                        if (miss_cnt == MISS_LAST) begin
                            state_n = ACQ;
                            run_n   = '0;
                            miss_n  = '0;
                        end else begin
                            miss_n = miss_cnt + 1'b1;
                        end
                    end
                end
                default: state_n = ACQ;
            endcase
        end
        // tick covers both the entering check and the lock-loss check
        tick_n = pv && (s == PH_BASE)
                 && (state == LOCKED || state_n == LOCKED);
        cnt_n = err_cnt;
        if (err_clr)
            cnt_n = '0;
        else if (err_n && err_cnt != '1)
            cnt_n = err_cnt + 1'b1;
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            s         <= '0;
            p         <= '0;
            sv        <= 1'b0;
            pv        <= 1'b0;
            state     <= ACQ;
            run_cnt   <= '0;
            miss_cnt  <= '0;
            phase_idx <= '0;
            tick      <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            s         <= ph_in;
            p         <= s;
            sv        <= 1'b1;
            pv        <= sv;
            state     <= state_n;
            run_cnt   <= run_n;
            miss_cnt  <= miss_n;
            tick      <= tick_n;
            err_pulse <= err_n;
            err_cnt   <= cnt_n;
            if (pv && legal_s)
                phase_idx <= idx;
        end
    end

endmodule

// File: tb/tb_phase_monitor.sv
// Directed bench for phase_monitor: lock, errors, saturation, reset.
// A second instance with ERR_W=2 shares the stimulus for saturation.
module tb_phase_monitor;

    logic       clkin = 1'b0;
    logic       reset;
    logic [7:0] ph_in;
    logic       err_clr, err_clr2;
    logic       locked, tick, err_pulse;
    logic [2:0] phase_idx;
    logic [7:0] err_cnt;
    logic       locked2, tick2, err_pulse2;
    logic [2:0] phase_idx2;
    logic [1:0] err_cnt2;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] cur;

    always #5 clkin = ~clkin;

    phase_monitor dut (
        .clkin     (clkin),
        .reset     (reset),
        .ph_in     (ph_in),
        .err_clr   (err_clr),
        .locked    (locked),
        .phase_idx (phase_idx),
        .tick      (tick),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    phase_monitor #(.ERR_W(2)) dut2 (
        .clkin     (clkin),
        .reset     (reset),
        .ph_in     (ph_in),
        .err_clr   (err_clr2),
        .locked    (locked2),
        .phase_idx (phase_idx2),
        .tick      (tick2),
        .err_pulse (err_pulse2),
        .err_cnt   (err_cnt2)
    );

    function automatic logic [7:0] rl(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [7:0] v);
        ph_in = v;
        cur   = v;
        @(posedge clkin);
        #1;
    endtask

    // Edge 0 is the first edge after release; lock lands on edge 17.
    task automatic lock_run();
        step(8'h0F);
        for (int e = 1; e <= 16; e++) step(rl(cur, 1));
        chk("pre_lock", locked, 0);
        chk("pre_lock_idx", phase_idx, 7);
        step(rl(cur, 1));
        chk("lock_e17", locked, 1);
        chk("lock_tick", tick, 1);
        chk("lock_idx", phase_idx, 0);
        chk("lock_errcnt", err_cnt, 0);
        chk("lock_errp", err_pulse, 0);
    endtask

    initial begin
        reset    = 1'b1;
        ph_in    = 8'h00;
        err_clr  = 1'b0;
        err_clr2 = 1'b0;
        cur      = 8'h00;
        repeat (2) @(posedge clkin);
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_idx", phase_idx, 0);
        chk("rst_tick", tick, 0);
        chk("rst_errp", err_pulse, 0);
        chk("rst_errcnt", err_cnt, 0);
        chk("rst_errcnt2", err_cnt2, 0);
        #3 reset = 1'b0;

        lock_run();
        chk("dut2_locked", locked2, 1);
        chk("dut2_tick", tick2, 1);
        chk("dut2_idx", phase_idx2, 0);
        for (int e = 18; e <= 33; e++) begin
            step(rl(cur, 1));
            chk("run_tick", tick, ((e - 1) % 8 == 0) ? 1 : 0);
            chk("run_idx", phase_idx, (e - 1) % 8);
            chk("run_locked", locked, 1);
        end

        // single phase skip: one bad check, lock kept
        step(rl(cur, 2));
        step(rl(cur, 1));
        chk("skip1_errp", err_pulse, 1);
        chk("skip1_locked", locked, 1);
        chk("skip1_errcnt", err_cnt, 1);
        chk("skip1_errcnt2", err_cnt2, 1);
        step(rl(cur, 1));
        chk("skip1_clean", err_pulse, 0);
        chk("skip1_hold", locked, 1);

        // illegal 0E sample: two bad checks, lock lost
        step(8'h0E);
        step(8'h87);
        chk("ill_errp1", err_pulse, 1);
        chk("ill_locked1", locked, 1);
        chk("ill_errcnt1", err_cnt, 2);
        chk("ill_idx_hold", phase_idx, 5);
        step(8'h0F);
        chk("ill_errp2", err_pulse, 1);
        chk("ill_locked2", locked, 0);
        chk("ill_errcnt2", err_cnt, 3);
        chk("ill_sat2", err_cnt2, 3);
        chk("ill_idx", phase_idx, 7);
        step(rl(cur, 1));
        chk("acq_errp", err_pulse, 0);
        for (int i = 2; i <= 15; i++) step(rl(cur, 1));
        chk("relock_pre", locked, 0);
        step(rl(cur, 1));
        chk("relock", locked, 1);

        // two skips in a row: lock lost, then relock after 16
        step(rl(cur, 2));
        step(rl(cur, 2));
        chk("dskip_errp1", err_pulse, 1);
        chk("dskip_lock1", locked, 1);
        chk("dskip_cnt1", err_cnt, 4);
        step(rl(cur, 1));
        chk("dskip_errp2", err_pulse, 1);
        chk("dskip_lock2", locked, 0);
        chk("dskip_cnt2", err_cnt, 5);
        chk("sat_5err", err_cnt2, 3);
        for (int i = 1; i <= 15; i++) step(rl(cur, 1));
        chk("drelock_pre", locked, 0);
        step(rl(cur, 1));
        chk("drelock", locked, 1);
        chk("drelock2", locked2, 1);

        // err_clr coincident with an error on the narrow instance
        step(rl(cur, 2));
        err_clr2 = 1'b1;
        step(rl(cur, 1));
        err_clr2 = 1'b0;
        chk("clr_win", err_cnt2, 0);
        chk("clr_other", err_cnt, 6);
        chk("clr_errp2", err_pulse2, 1);
        chk("clr_locked2", locked2, 1);
        step(rl(cur, 1));
        chk("clr_quiet", err_pulse, 0);
        err_clr = 1'b1;
        step(rl(cur, 1));
        err_clr = 1'b0;
        chk("clr_main", err_cnt, 0);
        step(rl(cur, 2));
        step(rl(cur, 1));
        chk("post_clr_cnt", err_cnt, 1);
        chk("post_clr_cnt2", err_cnt2, 1);
        repeat (3) step(rl(cur, 1));
        chk("pre_rst_lock", locked, 1);

        // asynchronous reset mid-lock
        #2 reset = 1'b1;
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_idx", phase_idx, 0);
        chk("arst_tick", tick, 0);
        chk("arst_errp", err_pulse, 0);
        chk("arst_errcnt", err_cnt, 0);
        chk("arst_errcnt2", err_cnt2, 0);
        @(posedge clkin);
        #4 reset = 1'b0;
        lock_run();

        // static patterns never lock
        #2 reset = 1'b1;
        @(posedge clkin);
        #4 reset = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step(8'hFF);
            chk("ff_locked", locked, 0);
            chk("ff_errcnt", err_cnt, 0);
            chk("ff_idx", phase_idx, 0);
        end
        for (int i = 0; i < 24; i++) begin
            step(8'h00);
            chk("z_locked", locked, 0);
            chk("z_errcnt", err_cnt, 0);
            chk("z_idx", phase_idx, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
